l6_control_sm: RTL and testbench

Parametrised multi-cycle control state machine for the 16-bit datapath processor. It sequences fetch, decode and execute of the instruction set, driving the register file, ALU, display and memory control strobes. New over the previous generation:
- configurable opcode width;
- a memory ready handshake with a bounded wait and error flag;
- resumable HALT;
- an optional compiled-in conditional branch.

---
 rtl/l6_control_sm.sv | 147 ++++++++++++++
 tb/tb_l6_control_sm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/l6_control_sm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit datapath processor.
// Define CTRL_BRANCH_EN to compile in the conditional branch (opcode 9, BRANCH state).
module l6_control_sm #(
  parameter int unsigned OPW         = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] operation,
  input  logic           mem_ready,
  input  logic           resume,
  input  logic           zero,
  output logic           _Extern,
  output logic           Gout,
  output logic           Ain,
  output logic           Gin,
  output logic           DPin,
  output logic           RdX,
  output logic           RdY,
  output logic           WrX,
  output logic           add_sub,
  output logic           pc_en,
  output logic           ILin,
  output logic           rf_sel,
  output logic           sw_sel,
  output logic           MemWr,
  output logic           AddrSel,
  output logic           mem_req,
  output logic           pc_load,
  output logic           mem_err,
  output logic [4:0]     cur_state
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [4:0] {
    FETCH   = 5'd0,  DECODE = 5'd1,  LOAD  = 5'd2,  READ_Y = 5'd3,
    READ_X  = 5'd4,  ADD    = 5'd5,  SUB   = 5'd6,  MV     = 5'd7,
    WRITE_X = 5'd8,  ADDI   = 5'd9,  SUBI  = 5'd10, DISP   = 5'd11,
    HALT    = 5'd12, STORE  = 5'd13, BRANCH = 5'd14
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          in_mem;
  logic          timeout;
  logic          branch_load;

  assign in_mem    = (state == LOAD) || (state == STORE);
  // mem_ready in the final counted cycle takes priority over the timeout
  assign timeout   = (MEM_TIMEOUT != 0) && in_mem && !mem_ready &&
                     (wait_cnt == CW'(MEM_TIMEOUT));
  assign cur_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (in_mem && (state_next == state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (timeout)
        mem_err <= 1'b1;
      else if ((state == HALT) && resume)
        mem_err <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (operation)
          OPW'(0): state_next = LOAD;
          OPW'(1): state_next = READ_Y;
          OPW'(2): state_next = READ_X;
          OPW'(3): state_next = READ_Y;
          OPW'(4): state_next = DISP;
          OPW'(5): state_next = HALT;
          OPW'(6): state_next = READ_X;
          OPW'(7): state_next = READ_X;
          OPW'(8): state_next = STORE;
`ifdef CTRL_BRANCH_EN
          OPW'(9): state_next = zero ? BRANCH : FETCH;
`endif
          default: state_next = FETCH;
        endcase
      end
      READ_Y: state_next = (operation == OPW'(3)) ? ADD : MV;
      READ_X: begin
        if (operation == OPW'(2))      state_next = SUB;
        else if (operation == OPW'(6)) state_next = SUBI;
        else                           state_next = ADDI;
      end
      LOAD, STORE: begin
        if (mem_ready)    state_next = FETCH;
        else if (timeout) state_next = HALT;
      end
      ADD, SUB, MV, ADDI, SUBI: state_next = WRITE_X;
      WRITE_X, DISP:            state_next = FETCH;
      HALT:    state_next = resume ? FETCH : HALT;
`ifdef CTRL_BRANCH_EN
      BRANCH:  state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase
  end

`ifdef CTRL_BRANCH_EN
  assign branch_load = (state == BRANCH);
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign branch_load = 1'b0;
`endif

  always_comb begin
    _Extern = 1'b0; Gout = 1'b0; Ain = 1'b0; Gin = 1'b0; DPin = 1'b0;
    RdX = 1'b0; RdY = 1'b0; WrX = 1'b0; add_sub = 1'b0; pc_en = 1'b0;
    ILin = 1'b0; rf_sel = 1'b0; sw_sel = 1'b0; MemWr = 1'b0; AddrSel = 1'b0;
    mem_req = 1'b0; pc_load = 1'b0;
    if (reset) begin
      pc_load = branch_load;
      case (state)
        FETCH:   begin pc_en = 1'b1; ILin = 1'b1; end
        LOAD:    begin _Extern = 1'b1; AddrSel = 1'b1; mem_req = 1'b1; WrX = mem_ready; end
        STORE:   begin AddrSel = 1'b1; mem_req = 1'b1; MemWr = mem_ready; end
        READ_Y:  begin Ain = 1'b1; RdY = 1'b1; end
        READ_X:  begin Ain = 1'b1; RdX = 1'b1; end
        ADD:     begin Gin = 1'b1; RdX = 1'b1; rf_sel = 1'b1; end
        SUB:     begin Gin = 1'b1; RdY = 1'b1; add_sub = 1'b1; rf_sel = 1'b1; end
        MV:      begin Gin = 1'b1; rf_sel = 1'b1; end
        ADDI:    begin Gin = 1'b1; sw_sel = 1'b1; end
        SUBI:    begin Gin = 1'b1; add_sub = 1'b1; sw_sel = 1'b1; end
        WRITE_X: begin Gout = 1'b1; WrX = 1'b1; end
        DISP:    begin DPin = 1'b1; RdX = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l6_control_sm.sv
// Directed self-checking bench for l6_control_sm (OPW=4, MEM_TIMEOUT=15).
module tb_l6_control_sm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] operation;
  logic       mem_ready, resume, zero;
  logic       _Extern, Gout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub, pc_en, ILin;
  logic       rf_sel, sw_sel, MemWr, AddrSel, mem_req, pc_load, mem_err;
  logic [4:0] cur_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [16:0] ADDR = 17'h1 << 0,  MWR = 17'h1 << 1,  SWS = 17'h1 << 2,
                          RFS  = 17'h1 << 3,  IL  = 17'h1 << 4,  PCE = 17'h1 << 5,
                          ASB  = 17'h1 << 6,  WRX = 17'h1 << 7,  RDY = 17'h1 << 8,
                          RDX  = 17'h1 << 9,  DPN = 17'h1 << 10, GIN = 17'h1 << 11,
                          AIN  = 17'h1 << 12, GOU = 17'h1 << 13, EXT = 17'h1 << 14,
                          PCL  = 17'h1 << 15, MRQ = 17'h1 << 16;
  localparam logic [16:0] FE = PCE | IL;

  int          exp_st[8];
  logic [16:0] exp_sb[8];

  l6_control_sm #(.OPW(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .operation(operation), .mem_ready(mem_ready),
    .resume(resume), .zero(zero), ._Extern(_Extern), .Gout(Gout), .Ain(Ain),
    .Gin(Gin), .DPin(DPin), .RdX(RdX), .RdY(RdY), .WrX(WrX), .add_sub(add_sub),
    .pc_en(pc_en), .ILin(ILin), .rf_sel(rf_sel), .sw_sel(sw_sel), .MemWr(MemWr),
    .AddrSel(AddrSel), .mem_req(mem_req), .pc_load(pc_load), .mem_err(mem_err),
    .cur_state(cur_state)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs();
    return {mem_req, pc_load, _Extern, Gout, Ain, Gin, DPin, RdX, RdY, WrX,
            add_sub, pc_en, ILin, rf_sel, sw_sel, MemWr, AddrSel};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks n cycles starting in FETCH, checking state and strobes each cycle.
  task automatic run_seq(input string tag, input logic [3:0] op, input int n);
    operation = op;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_st[%0d]", tag, i), 32'(cur_state), 32'(exp_st[i]));
      check($sformatf("%s_sb[%0d]", tag, i), 32'(obs()), 32'(exp_sb[i]));
      if (i < n - 1) step();
    end
  endtask

  task automatic store_to_limit(input string tag, input logic ready_last);
    operation = 4'd8;
    check({tag, "_fetch"}, 32'(cur_state), 32'd0);
    step();
    check({tag, "_decode"}, 32'(cur_state), 32'd1);
    step();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) mem_ready = ready_last;
      #1;
      check($sformatf("%s_st[%0d]", tag, k), 32'(cur_state), 32'd13);
      check($sformatf("%s_sb[%0d]", tag, k), 32'(obs()),
            32'(ADDR | MRQ | ((k == 16 && ready_last) ? MWR : 17'h0)));
      step();
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; operation = '0; mem_ready = 1'b0; resume = 1'b0; zero = 1'b0;
    step(); step();
    check("rst_state", 32'(cur_state), 32'd0);
    check("rst_strobes", 32'(obs()), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_strobes", 32'(obs()), 32'(FE));

    // Reset in the middle of a pending store
    operation = 4'd8;
    step();
    check("st_decode", 32'(cur_state), 32'd1);
    step();
    check("st_state", 32'(cur_state), 32'd13);
    check("st_strobes", 32'(obs()), 32'(ADDR | MRQ));
    step();
    reset = 1'b0;
    #1;
    check("midrst_state", 32'(cur_state), 32'd0);
    check("midrst_strobes", 32'(obs()), 32'd0);
    step();
    check("midrst_hold", 32'(obs()), 32'd0);
    check("midrst_err", 32'(mem_err), 32'd0);
    reset = 1'b1;
    #1;
    check("midrel_strobes", 32'(obs()), 32'(FE));

    exp_st = '{0, 1, 3, 5, 8, 0, 0, 0};
    exp_sb = '{FE, 17'h0, AIN | RDY, GIN | RDX | RFS, GOU | WRX, FE, 17'h0, 17'h0};
    run_seq("add", 4'd3, 6);
    exp_st = '{0, 1, 4, 6, 8, 0, 0, 0};
    exp_sb = '{FE, 17'h0, AIN | RDX, GIN | RDY | ASB | RFS, GOU | WRX, FE, 17'h0, 17'h0};
    run_seq("sub", 4'd2, 6);
    exp_st = '{0, 1, 3, 7, 8, 0, 0, 0};
    exp_sb = '{FE, 17'h0, AIN | RDY, GIN | RFS, GOU | WRX, FE, 17'h0, 17'h0};
    run_seq("mv", 4'd1, 6);
    exp_st = '{0, 1, 4, 9, 8, 0, 0, 0};
    exp_sb = '{FE, 17'h0, AIN | RDX, GIN | SWS, GOU | WRX, FE, 17'h0, 17'h0};
    run_seq("addi", 4'd7, 6);
    exp_st = '{0, 1, 4, 10, 8, 0, 0, 0};
    exp_sb = '{FE, 17'h0, AIN | RDX, GIN | ASB | SWS, GOU | WRX, FE, 17'h0, 17'h0};
    run_seq("subi", 4'd6, 6);
    exp_st = '{0, 1, 11, 0, 0, 0, 0, 0};
    exp_sb = '{FE, 17'h0, DPN | RDX, FE, 17'h0, 17'h0, 17'h0, 17'h0};
    run_seq("disp", 4'd4, 4);
    exp_st = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_sb = '{FE, 17'h0, FE, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    run_seq("unk15", 4'd15, 3);

    // Load completing after three wait cycles
    operation = 4'd0;
    step(); step();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) mem_ready = 1'b1;
      #1;
      check($sformatf("ld_st[%0d]", k), 32'(cur_state), 32'd2);
      check($sformatf("ld_sb[%0d]", k), 32'(obs()),
            32'(EXT | ADDR | MRQ | ((k == 4) ? WRX : 17'h0)));
      step();
    end
    mem_ready = 1'b0;
    check("ld_done", 32'(cur_state), 32'd0);
    check("ld_err", 32'(mem_err), 32'd0);

    // Ready arriving in the last counted cycle completes normally
    store_to_limit("stok", 1'b1);
    check("stok_state", 32'(cur_state), 32'd0);
    check("stok_err", 32'(mem_err), 32'd0);

    // Store that never sees mem_ready times out into HALT
    store_to_limit("sto", 1'b0);
    check("sto_state", 32'(cur_state), 32'd12);
    check("sto_err", 32'(mem_err), 32'd1);
    check("sto_strobes", 32'(obs()), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("sto_resume", 32'(cur_state), 32'd0);
    check("sto_errclr", 32'(mem_err), 32'd0);

    // Halt instruction holds until resume
    operation = 4'd5;
    step(); step();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hlt_st[%0d]", k), 32'(cur_state), 32'd12);
      check($sformatf("hlt_sb[%0d]", k), 32'(obs()), 32'd0);
      step();
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("hlt_resume", 32'(cur_state), 32'd0);

`ifdef CTRL_BRANCH_EN
    zero = 1'b1;
    exp_st = '{0, 1, 14, 0, 0, 0, 0, 0};
    exp_sb = '{FE, 17'h0, PCL, FE, 17'h0, 17'h0, 17'h0, 17'h0};
    run_seq("brz_t", 4'd9, 4);
    zero = 1'b0;
    exp_st = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_sb = '{FE, 17'h0, FE, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    run_seq("brz_nt", 4'd9, 3);
`else
    zero = 1'b1;
    exp_st = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_sb = '{FE, 17'h0, FE, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    run_seq("op9", 4'd9, 3);
    zero = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
